rho_inv_iter: RTL and testbench



---
 rtl/sha3_pkg.sv | 31 +++
 rtl/rho_inv_iter_if.sv | 21 ++
 rtl/rho_inv_lane_rot.sv | 16 +
 rtl/rho_inv_iter.sv | 94 +++++++++
 tb/tb_rho_inv_iter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sha3_pkg.sv
// Shared SHA3 sizes, rho offset table and FSM state type for the iterative
// inverse-rho unit.
package sha3_pkg;

    localparam int STATE_SIZE = 1600;
    localparam int Z_WIDTH    = 64;
    localparam int LANES      = 25;
    localparam int CD_SIZE    = 1024;

    localparam int unsigned RHO_OFFSETS [LANES] = '{
        0, 1, 190, 28, 91, 36, 300, 6, 55, 276, 3, 10, 171,
        153, 231, 105, 45, 15, 21, 136, 210, 66, 253, 120, 78
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    // Rotation amount actually applied to a lane; out-of-range lanes rotate by 0.
    function automatic logic [5:0] lane_rot_amount(input logic [4:0] idx);
        logic [5:0] amt;
        amt = '0;
        if (int'(idx) < LANES) begin
            amt = 6'(RHO_OFFSETS[idx] % 64);
        end
        return amt;
    endfunction

endpackage

// File: rtl/rho_inv_iter_if.sv
// Input/output valid-ready handshake bundle for rho_inv_iter.
interface rho_inv_iter_if;

    logic                              in_valid;
    logic                              in_ready;
    logic [0:sha3_pkg::STATE_SIZE-1]   in;
    logic                              out_valid;
    logic                              out_ready;
    logic [0:sha3_pkg::STATE_SIZE-1]   out;

    modport slave (
        input  in_valid, in, out_ready,
        output in_ready, out_valid, out
    );

    modport master (
        output in_valid, in, out_ready,
        input  in_ready, out_valid, out
    );

endinterface

// File: rtl/rho_inv_lane_rot.sv
// Combinational 64-bit lane rotator: out[j] = lane[(j + amount) mod 64].
module rho_inv_lane_rot
    import sha3_pkg::*;
(
    input  logic [0:Z_WIDTH-1] lane,
    input  logic [5:0]         amount,
    output logic [0:Z_WIDTH-1] out
);

    logic [0:2*Z_WIDTH-1] doubled;

    // Doubling the lane turns the modular wrap into a plain window select.
    assign doubled = {lane, lane};
    assign out     = doubled[amount +: Z_WIDTH];

endmodule

// File: rtl/rho_inv_iter.sv
// Iterative inverse-rho: one lane per cycle through a single shared rotator,
// with valid/ready handshakes on both sides.
//
// state | meaning
// IDLE  | waiting for a state; in_ready high
// BUSY  | rotating lane[cnt] back into the working register, cnt 0..24
// DONE  | result held on out with out_valid high until out_ready
module rho_inv_iter
    import sha3_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    rho_inv_iter_if.slave bus
);

    fsm_state_t              state;
    logic [4:0]              cnt;
    logic [0:STATE_SIZE-1]   work;
    logic                    in_ready_q;
    logic                    out_valid_q;

    logic [4:0]              sel;
    logic [10:0]             base;
    logic [5:0]              amt;
    logic [0:Z_WIDTH-1]      cur_lane;
    logic [0:Z_WIDTH-1]      rot_lane;

    // Clamp the lane select so an illegal counter value never reads past the state.
    assign sel      = (cnt < 5'(LANES)) ? cnt : 5'd0;
    assign base     = {sel, 6'b0};
    assign cur_lane = work[base +: Z_WIDTH];
    assign amt      = lane_rot_amount(sel);

    rho_inv_lane_rot u_rot (
        .lane   (cur_lane),
        .amount (amt),
        .out    (rot_lane)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            work        <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        work       <= bus.in;
                        cnt        <= '0;
                        state      <= BUSY;
                        in_ready_q <= 1'b0;
                    end
                end
                BUSY: begin
                    if (cnt >= 5'(LANES)) begin
                        state      <= IDLE;
                        cnt        <= '0;
                        in_ready_q <= 1'b1;
                    end else begin
                        work[base +: Z_WIDTH] <= rot_lane;
                        if (cnt == 5'(LANES - 1)) begin
                            state       <= DONE;
                            cnt         <= '0;
                            out_valid_q <= 1'b1;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state       <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    cnt         <= '0;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out       = work;

endmodule

// File: tb/tb_rho_inv_iter.sv
// Self-checking bench for rho_inv_iter against a lane/bit-index reference model.
module tb_rho_inv_iter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   cyc;

    rho_inv_iter_if bus();

    rho_inv_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam int unsigned OFFS [25] = '{
        0, 1, 190, 28, 91, 36, 300, 6, 55, 276, 3, 10, 171,
        153, 231, 105, 45, 15, 21, 136, 210, 66, 253, 120, 78
    };

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [0:1599] m_rho_inv(input logic [0:1599] s);
        logic [0:1599] r;
        r = '0;
        for (int i = 0; i < 25; i++)
            for (int j = 0; j < 64; j++)
                r[i*64 + j] = s[i*64 + int'((j + OFFS[i]) % 64)];
        return r;
    endfunction

    function automatic logic [0:1599] m_rho(input logic [0:1599] s);
        logic [0:1599] r;
        r = '0;
        for (int i = 0; i < 25; i++)
            for (int j = 0; j < 64; j++)
                r[i*64 + int'((j + OFFS[i]) % 64)] = s[i*64 + j];
        return r;
    endfunction

    function automatic logic [0:1599] rand_state();
        logic [0:1599] s;
        for (int k = 0; k < 50; k++) s[k*32 +: 32] = $urandom;
        return s;
    endfunction

    function automatic int diff_lane(input logic [0:1599] a, input logic [0:1599] b);
        for (int i = 0; i < 25; i++)
            if (a[i*64 +: 64] !== b[i*64 +: 64]) return i;
        return 0;
    endfunction

    task automatic wait_sig(input int sel, input logic level, output bit ok);
        ok = 0;
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (((sel == 0) ? bus.in_ready : bus.out_valid) === level) begin
                ok = 1;
                break;
            end
        end
    endtask

    // Feeds one state with out_ready high; returns result, accept-to-valid latency.
    task automatic process(input logic [0:1599] s, output logic [0:1599] r,
                           output int lat, output bit ok);
        bit w;
        r = '0; lat = 0; ok = 0;
        wait_sig(0, 1'b1, w);
        if (!w) return;
        bus.in = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk); lat++; #1;
            if (bus.out_valid === 1'b1) begin
                ok = 1;
                break;
            end
        end
        if (!ok) return;
        r = bus.out;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        checks++;
        if (bus.out !== '0) begin
            failures++;
            $display("FAIL reset_out got lane%0d=%h want 0", diff_lane(bus.out, '0),
                     bus.out[diff_lane(bus.out, '0)*64 +: 64]);
        end
    endtask

    task automatic test_single_bit();
        logic [0:1599] s, e, r;
        int lat; bit ok;
        int src [2] = '{65, 190};
        int dst [2] = '{64, 128};
        for (int t = 0; t < 2; t++) begin
            s = '0; e = '0;
            s[src[t]] = 1'b1;
            e[dst[t]] = 1'b1;
            process(s, r, lat, ok);
            checks++;
            if (!ok || r !== e) begin
                failures++;
                $display("FAIL single_bit src=%0d ok=%0b got lane%0d=%h want %h", src[t], ok,
                         diff_lane(r, e), r[diff_lane(r, e)*64 +: 64], e[diff_lane(r, e)*64 +: 64]);
            end
        end
    endtask

    task automatic test_lane0_identity();
        logic [0:1599] s, r;
        logic [63:0] v;
        int lat; bit ok;
        v = 64'hFFFF_0000_1234_5678;
        s = '0;
        s[0:63] = v;
        process(s, r, lat, ok);
        checks++;
        if (!ok || r !== s) begin
            failures++;
            $display("FAIL lane0_identity ok=%0b got lane%0d=%h want %h", ok,
                     diff_lane(r, s), r[diff_lane(r, s)*64 +: 64], s[diff_lane(r, s)*64 +: 64]);
        end
        checks++;
        if (lat != 25) begin
            failures++;
            $display("FAIL latency got %0d want 25", lat);
        end
    endtask

    task automatic test_round_trip();
        logic [0:1599] s, e, r;
        int lat; bit ok;
        for (int n = 0; n < 200; n++) begin
            s = rand_state();
            e = m_rho_inv(s);
            process(s, r, lat, ok);
            checks++;
            if (!ok || r !== e) begin
                failures++;
                $display("FAIL rt_inv n=%0d ok=%0b got lane%0d=%h want %h", n, ok,
                         diff_lane(r, e), r[diff_lane(r, e)*64 +: 64], e[diff_lane(r, e)*64 +: 64]);
            end
            checks++;
            if (m_rho(r) !== s) begin
                failures++;
                $display("FAIL rt_rho_of_out n=%0d lane%0d got %h want %h", n, diff_lane(m_rho(r), s),
                         m_rho(r)[diff_lane(m_rho(r), s)*64 +: 64], s[diff_lane(m_rho(r), s)*64 +: 64]);
            end
            process(m_rho(s), r, lat, ok);
            checks++;
            if (!ok || r !== s) begin
                failures++;
                $display("FAIL rt_inv_of_rho n=%0d ok=%0b got lane%0d=%h want %h", n, ok,
                         diff_lane(r, s), r[diff_lane(r, s)*64 +: 64], s[diff_lane(r, s)*64 +: 64]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [0:1599] s, e, snap, r;
        int lat; bit ok;
        s = rand_state();
        e = m_rho_inv(s);
        bus.out_ready = 1'b0;
        wait_sig(0, 1'b1, ok);
        bus.in = s;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        wait_sig(1, 1'b1, ok);
        snap = bus.out;
        checks++;
        if (!ok || snap !== e) begin
            failures++;
            $display("FAIL bp_result ok=%0b got lane%0d=%h want %h", ok,
                     diff_lane(snap, e), snap[diff_lane(snap, e)*64 +: 64], e[diff_lane(snap, e)*64 +: 64]);
        end
        for (int n = 0; n < 10; n++) begin
            bus.in = rand_state();
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
            checks++;
            if (bus.out !== e || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_stall n=%0d got out_lane%0d=%h valid=%b ready=%b want %h 1 0", n,
                         diff_lane(bus.out, e), bus.out[diff_lane(bus.out, e)*64 +: 64],
                         bus.out_valid, bus.in_ready, e[diff_lane(bus.out, e)*64 +: 64]);
            end
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
        s = rand_state();
        process(s, r, lat, ok);
        checks++;
        if (!ok || r !== m_rho_inv(s)) begin
            failures++;
            $display("FAIL bp_after ok=%0b got lane%0d=%h want %h", ok, diff_lane(r, m_rho_inv(s)),
                     r[diff_lane(r, m_rho_inv(s))*64 +: 64], m_rho_inv(s)[diff_lane(r, m_rho_inv(s))*64 +: 64]);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:1599] s [4];
        int vcyc [3];
        bit ok;
        for (int k = 0; k < 4; k++) s[k] = rand_state();
        bus.in = s[0];
        bus.in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_sig(0, 1'b1, ok);
            if (ok) wait_sig(0, 1'b0, ok);
            bus.in = s[k+1];
            if (ok) wait_sig(1, 1'b1, ok);
            vcyc[k] = cyc;
            checks++;
            if (!ok || bus.out !== m_rho_inv(s[k])) begin
                failures++;
                $display("FAIL b2b_data k=%0d ok=%0b got lane%0d=%h want %h", k, ok,
                         diff_lane(bus.out, m_rho_inv(s[k])),
                         bus.out[diff_lane(bus.out, m_rho_inv(s[k]))*64 +: 64],
                         m_rho_inv(s[k])[diff_lane(bus.out, m_rho_inv(s[k]))*64 +: 64]);
            end
        end
        bus.in_valid = 1'b0;
        for (int k = 1; k < 3; k++) begin
            checks++;
            if (vcyc[k] - vcyc[k-1] != 27) begin
                failures++;
                $display("FAIL b2b_spacing k=%0d got %0d want 27", k, vcyc[k] - vcyc[k-1]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        logic [0:1599] s, r;
        int lat; bit ok;
        wait_sig(0, 1'b1, ok);
        bus.in = rand_state();
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        checks++;
        if (bus.out !== '0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid got out_lane%0d=%h valid=%b ready=%b want 0 0 1",
                     diff_lane(bus.out, '0), bus.out[diff_lane(bus.out, '0)*64 +: 64],
                     bus.out_valid, bus.in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        s = rand_state();
        process(s, r, lat, ok);
        checks++;
        if (!ok || r !== m_rho_inv(s) || lat != 25) begin
            failures++;
            $display("FAIL reset_fresh ok=%0b lat=%0d got lane%0d=%h want %h", ok, lat,
                     diff_lane(r, m_rho_inv(s)), r[diff_lane(r, m_rho_inv(s))*64 +: 64],
                     m_rho_inv(s)[diff_lane(r, m_rho_inv(s))*64 +: 64]);
        end
    endtask

    initial begin
        clk = 1'b0;
        cyc = 0;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_single_bit();
        test_lane0_identity();
        test_round_trip();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
